seq_detect_param: RTL
=====================

SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 Parameter LEN, default 3, SHALL set the pattern length in bits; legal range 2..8.
REQ-002 Parameter PATTERN, default 3'b100, LEN bits wide, SHALL be the target sequence; PATTERN[LEN-1] is the first bit received.
REQ-003 Parameter OVERLAP, default 1, SHALL select overlapped detection (1) or non-overlapped detection (0).
REQ-004 Parameter CNT_W, default 8, SHALL set the width of the match counter; legal range 1..16.
REQ-005 Port clock, input, 1 bit, SHALL be the single clock; all state changes on its rising edge.
REQ-006 Port reset, input, 1 bit, SHALL be an asynchronous, active-low reset.
REQ-007 Port en, input, 1 bit, SHALL mark I as valid for the current edge.
REQ-008 Port I, input, 1 bit, SHALL be the serial data bit.
REQ-009 Port clr, input, 1 bit, SHALL be a synchronous clear of detector state and counter.
REQ-010 Port F, output, 1 bit, SHALL be the registered one-cycle match pulse.
REQ-011 Port S, output, $clog2(LEN+1) bits, SHALL be the current state: the number of pattern bits matched, 0..LEN-1.
REQ-012 Port match_count, output, CNT_W bits, SHALL be the saturating count of detected matches.

Function
REQ-013 S SHALL hold the length k of the longest pattern prefix that equals a suffix of the accepted bit stream, with k < LEN.
REQ-014 On an edge with en=1, the next prefix length j SHALL be the largest j <= k+1 such that the first j pattern bits equal the last j bits of (matched prefix followed by I).
REQ-015 The next-state table SHALL be fixed at elaboration from PATTERN; no runtime pattern load.
REQ-016 When j reaches LEN, F SHALL be 1 for exactly the following cycle (latency 1 edge after the completing bit).
REQ-017 On a match with OVERLAP=1, S SHALL become the longest proper prefix of PATTERN that is also a suffix of PATTERN.
REQ-018 On a match with OVERLAP=0, S SHALL become 0.
REQ-019 With en=0, S and match_count SHALL hold, I SHALL be ignored, and F SHALL be 0.
REQ-020 Each match SHALL increment match_count by 1 in the same edge that sets F; at all-ones the counter SHALL saturate and hold.
REQ-021 With clr=1, S and match_count SHALL go to 0 and F to 0 on that edge, taking priority over en and over a simultaneous match.
REQ-022 Elaboration SHALL fail if LEN or CNT_W is out of range.

Reset
REQ-023 With reset=0, S, F and match_count SHALL go to 0 immediately, independent of clock.
REQ-024 Deassertion of reset SHALL be synchronous; the first bit accepted is the first edge with en=1 after deassertion.
REQ-025 Reset mid-sequence SHALL discard any partial match; no match spanning a reset is reported.

Structure
REQ-026 Package seq_det_pkg SHALL hold the range constants and the elaboration-time next-state and failure-value function.
REQ-027 The saturating counter SHALL be sub-module seq_det_sat_counter (parameter CNT_W; inputs clock, reset, inc, clr; output count).
REQ-028 The state register, next-state lookup and F register SHALL live in seq_detect_param.

Verification
REQ-029 LEN=3, PATTERN=100, en=1, stream 1,0,0,1,0,0 -> F pulses after bits 3 and 6; match_count=2; S sequence 1,2,0,1,2,0.
REQ-030 LEN=4, PATTERN=1010, OVERLAP=1, stream 1,0,1,0,1,0 -> F after bits 4 and 6; match_count=2. With OVERLAP=0 -> F after bit 4 only; match_count=1.
REQ-031 PATTERN=100, stream 1,0,en=0 for 3 cycles with I=1, then 0 -> S holds 2 through the gap; F pulses after the final 0.
REQ-032 CNT_W=2, five PATTERN=100 matches -> match_count 1,2,3,3,3; F pulses all five times.
REQ-033 PATTERN=100, reset=0 asserted between a clock edge after 1,0 -> S=0 at once; a later 0 does not match; a following 1,0,0 matches.
REQ-034 clr=1 on the edge that completes a match -> F=0, S=0, match_count=0.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared constants and elaboration-time helpers for the serial pattern detector.
package seq_det_pkg;

  localparam int unsigned LEN_MIN   = 2;
  localparam int unsigned LEN_MAX   = 8;
  localparam int unsigned CNT_W_MIN = 1;
  localparam int unsigned CNT_W_MAX = 16;

  // Next matched-prefix length after seeing bit b while k bits of pat are matched.
  // pat is right-aligned in 8 bits; pat[len-1] is the first bit of the pattern.
  // May return len, which means the pattern just completed.
  function automatic int next_state(logic [7:0] pat, int len, int k, logic b);
    logic [8:0] seq;
    logic       ok;
    int         n;
    int         res;
    seq = '0;
    n   = k + 1;
    res = 0;
    // Rebuild the matched prefix followed by the new bit, oldest bit at index 0
    for (int m = 0; m < 9; m++) begin
      if (m < k) begin
        seq[m] = pat[len-1-m];
      end else if (m == k) begin
        seq[m] = b;
      end
    end
    for (int j = 1; j <= n; j++) begin
      ok = 1'b1;
      for (int m = 0; m < j; m++) begin
        if (pat[len-1-m] != seq[n-j+m]) begin
          ok = 1'b0;
        end
      end
      if (ok) begin
        res = j;
      end
    end
    return res;
  endfunction

  // Longest proper prefix of pat that is also a suffix of pat (resume point after a match).
  function automatic int fail_value(logic [7:0] pat, int len);
    logic ok;
    int   res;
    res = 0;
    for (int k = 1; k < len; k++) begin
      ok = 1'b1;
      for (int m = 0; m < k; m++) begin
        if (pat[len-1-m] != pat[k-1-m]) begin
          ok = 1'b0;
        end
      end
      if (ok) begin
        res = k;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/seq_det_sat_counter.sv
// Saturating event counter with synchronous clear.
module seq_det_sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  // Count increments, holding at all-ones; clear wins over increment
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seq_detect_param.sv
// Parameterised serial pattern detector with a prefix-length state machine.
module seq_detect_param
  import seq_det_pkg::*;
#(
  parameter int unsigned          LEN     = 3,
  parameter logic [LEN-1:0]       PATTERN = 3'b100,
  parameter bit                   OVERLAP = 1'b1,
  parameter int unsigned          CNT_W   = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       en,
  input  logic                       I,
  input  logic                       clr,
  output logic                       F,
  output logic [$clog2(LEN+1)-1:0]   S,
  output logic [CNT_W-1:0]           match_count
);

  localparam int unsigned SW    = $clog2(LEN + 1);
  localparam int unsigned TBL_N = 1 << SW;
  localparam logic [7:0]  PAT8  = 8'(PATTERN);

  // Reject illegal sizing at elaboration
  if ((LEN < LEN_MIN) || (LEN > LEN_MAX)) begin : g_bad_len
    $error("seq_detect_param: LEN out of range");
  end
  if ((CNT_W < CNT_W_MIN) || (CNT_W > CNT_W_MAX)) begin : g_bad_cnt
    $error("seq_detect_param: CNT_W out of range");
  end

  localparam logic [SW-1:0] FAIL_S  = SW'(fail_value(PAT8, int'(LEN)));
  localparam logic [SW-1:0] DONE_S  = SW'(LEN);

  logic [SW-1:0] tbl0 [TBL_N];
  logic [SW-1:0] tbl1 [TBL_N];

  // Next-state table fixed from PATTERN; unreachable rows park at 0
  for (genvar k = 0; k < int'(TBL_N); k++) begin : g_tbl
    if (k < int'(LEN)) begin : g_live
      localparam int N0 = next_state(PAT8, int'(LEN), k, 1'b0);
      localparam int N1 = next_state(PAT8, int'(LEN), k, 1'b1);
      assign tbl0[k] = SW'(N0);
      assign tbl1[k] = SW'(N1);
    end else begin : g_dead
      assign tbl0[k] = '0;
      assign tbl1[k] = '0;
    end
  end

  logic [SW-1:0] s_q;
  logic [SW-1:0] s_next;
  logic          f_q;
  logic          f_next;
  logic [SW-1:0] j_c;
  logic          hit_c;

  // Next prefix length, match pulse and counter increment
  always_comb begin
    s_next = s_q;
    f_next = 1'b0;
    hit_c  = 1'b0;
    j_c    = I ? tbl1[s_q] : tbl0[s_q];
    if (clr) begin
      s_next = '0;
    end else if (en) begin
      if (j_c == DONE_S) begin
        hit_c  = 1'b1;
        f_next = 1'b1;
        s_next = OVERLAP ? FAIL_S : '0;
      end else begin
        s_next = j_c;
      end
    end
  end

  // State and match-pulse registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s_q <= '0;
      f_q <= 1'b0;
    end else begin
      s_q <= s_next;
      f_q <= f_next;
    end
  end

  seq_det_sat_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (hit_c),
    .clr   (clr),
    .count (match_count)
  );

  assign F = f_q;
  assign S = s_q;

endmodule
